// File: rtl/host_tag_alloc_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// host_tag_alloc_arb: round-robin PCIe tag allocator backed by a free-list FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
module host_tag_alloc_arb #(
  parameter int NUM_REQ         = 4,
  parameter int TAG_WIDTH       = 10,
  parameter int NUM_TAGS        = 256,
  parameter int MAX_OUTSTANDING = 256,
  parameter int PFVF_WIDTH      = 15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*PFVF_WIDTH-1:0] req_pfvf,
  output logic [NUM_REQ-1:0]            grant,
  output logic [TAG_WIDTH-1:0]          grant_tag,
  output logic [PFVF_WIDTH-1:0]         grant_pfvf,
  input  logic                          release_valid,
  input  logic [TAG_WIDTH-1:0]          release_tag,
  output logic                          init_done,
  output logic [TAG_WIDTH:0]            outstanding,
  output logic                          pool_empty,
  output logic                          err_double_free,
  output logic                          err_tag_oor
);

  localparam int c_PTR_W = $clog2(NUM_TAGS);
  localparam int c_IDX_W = $clog2(NUM_REQ);
  localparam logic [c_PTR_W:0]   c_FULL_CNT = (c_PTR_W+1)'(NUM_TAGS);
  localparam logic [c_PTR_W:0]   c_CNT_ONE  = (c_PTR_W+1)'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
  localparam logic [c_PTR_W-1:0] c_LAST_TAG = c_PTR_W'(NUM_TAGS-1);
  localparam logic [TAG_WIDTH:0] c_NUM_TAGS = (TAG_WIDTH+1)'(NUM_TAGS);
  localparam logic [TAG_WIDTH:0] c_MAX_OUT  = (TAG_WIDTH+1)'(MAX_OUTSTANDING);
  localparam logic [TAG_WIDTH:0] c_OUT_ONE  = (TAG_WIDTH+1)'(1);
  localparam logic [c_IDX_W-1:0] c_LAST_REQ = c_IDX_W'(NUM_REQ-1);
  localparam logic [0:0]         c_ST_INIT  = 1'b0;
  localparam logic [0:0]         c_ST_RUN   = 1'b1;

  logic [0:0]            r_state, w_state_nxt;
  logic                  w_init_wr, w_run;
  logic [c_PTR_W-1:0]    r_init_cnt;
  logic [TAG_WIDTH-1:0]  r_mem [NUM_TAGS];
  logic [c_PTR_W-1:0]    r_rd_ptr, r_wr_ptr;
  logic [c_PTR_W:0]      r_count;
  logic [NUM_TAGS-1:0]   r_bitmap;
  logic [TAG_WIDTH:0]    r_outstanding;
  logic [c_IDX_W-1:0]    r_last;
  logic [NUM_REQ-1:0]    r_grant;
  logic [TAG_WIDTH-1:0]  r_grant_tag;
  logic [PFVF_WIDTH-1:0] r_grant_pfvf;
  logic                  r_init_done, r_err_df, r_err_oor;

  logic                  w_pool_empty, w_sel_found, w_pop;
  logic [NUM_REQ-1:0]    w_elig, w_sel_oh;
  logic [c_IDX_W-1:0]    w_sel_idx;
  logic [PFVF_WIDTH-1:0] w_pfvf_arr [NUM_REQ];
  logic [TAG_WIDTH-1:0]  w_pop_tag;
  logic [c_PTR_W-1:0]    w_pop_idx, w_rel_idx, w_mem_waddr;
  logic                  w_rel_oor, w_rel_inuse, w_rel_ok, w_rel_df;
  logic                  w_mem_we;
  logic [TAG_WIDTH-1:0]  w_mem_wdata;

  function automatic logic [c_IDX_W-1:0] f_wrap(input logic [c_IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return c_IDX_W'(s);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= c_ST_INIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == c_ST_INIT && r_init_cnt == c_LAST_TAG) w_state_nxt = c_ST_RUN;
  end

  always_comb begin
    w_init_wr = (r_state == c_ST_INIT);
    w_run     = (r_state == c_ST_RUN);
  end

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_pfvf
      assign w_pfvf_arr[g] = req_pfvf[g*PFVF_WIDTH +: PFVF_WIDTH];
    end
  endgenerate

  assign w_pool_empty = !r_init_done || (r_count == '0) || (r_outstanding >= c_MAX_OUT);
  // A requester whose grant is on display this cycle is skipped.
  assign w_elig = req_valid & ~r_grant;

  // Descending scan so the smallest offset from the last winner is kept.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = r_last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (w_elig[f_wrap(r_last, k)]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = f_wrap(r_last, k);
      end
    end
  end

  assign w_sel_oh  = NUM_REQ'(1) << w_sel_idx;
  assign w_pop     = w_sel_found && !w_pool_empty;
  assign w_pop_tag = r_mem[r_rd_ptr];
  assign w_pop_idx = w_pop_tag[c_PTR_W-1:0];

  assign w_rel_oor   = release_valid && ({1'b0, release_tag} >= c_NUM_TAGS);
  assign w_rel_idx   = release_tag[c_PTR_W-1:0];
  assign w_rel_inuse = r_bitmap[w_rel_idx];
  assign w_rel_ok    = release_valid && !w_rel_oor && w_run && w_rel_inuse;
  assign w_rel_df    = release_valid && !w_rel_oor && !(w_run && w_rel_inuse);

  assign w_mem_we    = rst_n && (w_init_wr || w_rel_ok);
  assign w_mem_waddr = w_init_wr ? r_init_cnt : r_wr_ptr;
  assign w_mem_wdata = w_init_wr ? TAG_WIDTH'(r_init_cnt) : release_tag;

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_init_cnt    <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_bitmap      <= '0;
      r_outstanding <= '0;
      r_last        <= c_LAST_REQ;
      r_grant       <= '0;
      r_grant_tag   <= '0;
      r_grant_pfvf  <= '0;
      r_init_done   <= 1'b0;
      r_err_df      <= 1'b0;
      r_err_oor     <= 1'b0;
    end else begin
      r_init_done <= w_run;
      r_err_oor   <= w_rel_oor;
      r_err_df    <= w_rel_df;
      if (w_init_wr) r_init_cnt <= r_init_cnt + c_PTR_ONE;

      if (w_init_wr && r_init_cnt == c_LAST_TAG) begin
        r_count <= c_FULL_CNT;
      end else begin
        case ({w_rel_ok, w_pop})
          2'b10:   r_count <= r_count + c_CNT_ONE;
          2'b01:   r_count <= r_count - c_CNT_ONE;
          default: r_count <= r_count;
        endcase
      end

      case ({w_rel_ok, w_pop})
        2'b10:   r_outstanding <= r_outstanding - c_OUT_ONE;
        2'b01:   r_outstanding <= r_outstanding + c_OUT_ONE;
        default: r_outstanding <= r_outstanding;
      endcase

      if (w_pop) begin
        r_rd_ptr            <= r_rd_ptr + c_PTR_ONE;
        r_bitmap[w_pop_idx] <= 1'b1;
        r_last              <= w_sel_idx;
      end
      if (w_rel_ok) begin
        r_wr_ptr            <= r_wr_ptr + c_PTR_ONE;
        r_bitmap[w_rel_idx] <= 1'b0;
      end

      r_grant      <= w_pop ? w_sel_oh : '0;
      r_grant_tag  <= w_pop ? w_pop_tag : '0;
      r_grant_pfvf <= w_pop ? w_pfvf_arr[w_sel_idx] : '0;
    end
  end

  assign grant           = r_grant;
  assign grant_tag       = r_grant_tag;
  assign grant_pfvf      = r_grant_pfvf;
  assign init_done       = r_init_done;
  assign outstanding     = r_outstanding;
  assign pool_empty      = w_pool_empty;
  assign err_double_free = r_err_df;
  assign err_tag_oor     = r_err_oor;

endmodule
`default_nettype wire
